// File: rtl/l2_instruction_block_responder.sv
// rtl/l2_instruction_block_responder.sv - L2 responder fetching a 16-word instruction block per L1 miss
// Optional build macro: CRITICAL_WORD_FIRST_EN (fetch the requested word first, wrapping through the block).
module l2_instruction_block_responder #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORD_PER_BLOCK = 16
) (
    input  logic                                   CLK,
    input  logic                                   RST_N,
    input  logic                                   ADDRESS_TO_L2_VALID_INS,
    output logic                                   ADDRESS_TO_L2_READY_INS,
    input  logic [ADDRESS_WIDTH-3:0]               ADDRESS_TO_L2_INS,
    output logic                                   DATA_FROM_L2_VALID_INS,
    input  logic                                   DATA_FROM_L2_READY_INS,
    output logic [WORD_PER_BLOCK*DATA_WIDTH-1:0]   DATA_FROM_L2_INS,
    output logic                                   MEM_ADDRESS_VALID,
    input  logic                                   MEM_ADDRESS_READY,
    output logic [ADDRESS_WIDTH-3:0]               MEM_ADDRESS,
    input  logic                                   MEM_DATA_VALID,
    input  logic [DATA_WIDTH-1:0]                  MEM_DATA
);
    localparam int BLOCK_WIDTH = WORD_PER_BLOCK * DATA_WIDTH;
    localparam int WORD_SELECT = $clog2(WORD_PER_BLOCK);
    localparam int WADDR_WIDTH = ADDRESS_WIDTH - 2;
    localparam int BASE_WIDTH  = WADDR_WIDTH - WORD_SELECT;

    typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [BASE_WIDTH-1:0]   base;
    logic [WORD_SELECT-1:0]  start_idx;
    logic [WORD_SELECT-1:0]  req_start;
    logic [WORD_SELECT:0]    issue_cnt;
    logic [WORD_SELECT:0]    recv_cnt;
    logic [WORD_SELECT-1:0]  issue_idx;
    logic [WORD_SELECT-1:0]  recv_idx;
    logic [DATA_WIDTH-1:0]   block_words [WORD_PER_BLOCK];
    logic                    issue_hs;
    logic                    beat_in;
    logic                    last_beat;

`ifdef CRITICAL_WORD_FIRST_EN
    assign req_start = ADDRESS_TO_L2_INS[WORD_SELECT-1:0];
`else
    logic unused_low_bits;
    assign req_start       = '0;
    assign unused_low_bits = ^ADDRESS_TO_L2_INS[WORD_SELECT-1:0];
`endif

    // Counters are one bit wider than the word index so the MSB flags "all 16 done".
    assign issue_idx = start_idx + issue_cnt[WORD_SELECT-1:0];
    assign recv_idx  = start_idx + recv_cnt[WORD_SELECT-1:0];
    assign issue_hs  = MEM_ADDRESS_VALID && MEM_ADDRESS_READY;
    assign beat_in   = (state == FETCH) && MEM_DATA_VALID;
    assign last_beat = beat_in && !recv_cnt[WORD_SELECT] && (&recv_cnt[WORD_SELECT-1:0]);

    assign ADDRESS_TO_L2_READY_INS = (state == IDLE);
    assign DATA_FROM_L2_VALID_INS  = (state == RESP);
    assign MEM_ADDRESS_VALID       = (state == FETCH) && !issue_cnt[WORD_SELECT];
    assign MEM_ADDRESS             = {base, issue_idx};

    // Word 0 occupies the most significant slice of the returned block.
    for (genvar g = 0; g < WORD_PER_BLOCK; g++) begin : g_pack
        assign DATA_FROM_L2_INS[BLOCK_WIDTH-1-g*DATA_WIDTH -: DATA_WIDTH] = block_words[g];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ADDRESS_TO_L2_VALID_INS) state_next = FETCH;
            FETCH:   if (last_beat) state_next = RESP;
            RESP:    if (DATA_FROM_L2_READY_INS) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            base      <= '0;
            start_idx <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            for (int i = 0; i < WORD_PER_BLOCK; i++) begin
                block_words[i] <= '0;
            end
        end else begin
            if ((state == IDLE) && ADDRESS_TO_L2_VALID_INS) begin
                base      <= ADDRESS_TO_L2_INS[WADDR_WIDTH-1:WORD_SELECT];
                start_idx <= req_start;
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end
            if (issue_hs) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (beat_in) begin
                block_words[recv_idx] <= MEM_DATA;
                recv_cnt              <= recv_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_l2_instruction_block_responder.sv
// tb/tb_l2_instruction_block_responder.sv - scoreboard bench for l2_instruction_block_responder
module tb_l2_instruction_block_responder;
    logic         CLK = 1'b0;
    logic         RST_N;
    logic         ADDRESS_TO_L2_VALID_INS;
    logic         ADDRESS_TO_L2_READY_INS;
    logic [29:0]  ADDRESS_TO_L2_INS;
    logic         DATA_FROM_L2_VALID_INS;
    logic         DATA_FROM_L2_READY_INS;
    logic [511:0] DATA_FROM_L2_INS;
    logic         MEM_ADDRESS_VALID;
    logic         MEM_ADDRESS_READY;
    logic [29:0]  MEM_ADDRESS;
    logic         MEM_DATA_VALID;
    logic [31:0]  MEM_DATA;

    l2_instruction_block_responder dut (
        .CLK                     (CLK),
        .RST_N                   (RST_N),
        .ADDRESS_TO_L2_VALID_INS (ADDRESS_TO_L2_VALID_INS),
        .ADDRESS_TO_L2_READY_INS (ADDRESS_TO_L2_READY_INS),
        .ADDRESS_TO_L2_INS       (ADDRESS_TO_L2_INS),
        .DATA_FROM_L2_VALID_INS  (DATA_FROM_L2_VALID_INS),
        .DATA_FROM_L2_READY_INS  (DATA_FROM_L2_READY_INS),
        .DATA_FROM_L2_INS        (DATA_FROM_L2_INS),
        .MEM_ADDRESS_VALID       (MEM_ADDRESS_VALID),
        .MEM_ADDRESS_READY       (MEM_ADDRESS_READY),
        .MEM_ADDRESS             (MEM_ADDRESS),
        .MEM_DATA_VALID          (MEM_DATA_VALID),
        .MEM_DATA                (MEM_DATA)
    );

    always #5 CLK = ~CLK;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           beat_cnt = 0;
    int           hs_cyc = -10;
    bit           alt_mode = 0;
    logic [29:0]  exp_addr_q [$];
    logic [511:0] exp_blk_q [$];
    logic [511:0] last_blk = '0;
    logic [511:0] first_blk = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [511:0] make_blk(input logic [29:0] base);
        logic [511:0] b;
        logic [29:0]  w;
        b = '0;
        for (int i = 0; i < 16; i++) begin
            w = base + 30'(i);
            b[511-i*32 -: 32] = {2'b00, w};
        end
        return b;
    endfunction

    // Expected fetch order and returned block for one request.
    task automatic push_expect(input logic [29:0] addr);
        logic [29:0] base;
        logic [3:0]  start;
        logic [3:0]  idx;
        base = {addr[29:4], 4'h0};
`ifdef CRITICAL_WORD_FIRST_EN
        start = addr[3:0];
`else
        start = 4'h0;
`endif
        for (int i = 0; i < 16; i++) begin
            idx = start + 4'(i);
            exp_addr_q.push_back({base[29:4], idx});
        end
        exp_blk_q.push_back(make_blk(base));
    endtask

    // Memory model: 2-cycle read latency, data equals the word address.
    initial begin : mem_model
        bit          p0_v = 0;
        bit          p1_v = 0;
        logic [29:0] p0_a = '0;
        logic [29:0] p1_a = '0;
        bit          chk_lat = 0;
        bit          stall_prev = 0;
        logic [29:0] stall_addr = '0;
        MEM_ADDRESS_READY = 1'b1;
        MEM_DATA_VALID    = 1'b0;
        MEM_DATA          = '0;
        forever begin
            @(negedge CLK);
            if (chk_lat) begin
                chk("resp_latency", DATA_FROM_L2_VALID_INS, 1);
                chk_lat = 0;
            end
            if (!RST_N) beat_cnt = 0;
            if (stall_prev && RST_N) begin
                chk("mem_valid_hold", MEM_ADDRESS_VALID, 1);
                chk("mem_addr_hold", MEM_ADDRESS, stall_addr);
            end
            MEM_DATA_VALID = p1_v;
            MEM_DATA       = {2'b00, p1_a};
            p1_v = p0_v;
            p1_a = p0_a;
            if (MEM_DATA_VALID && RST_N && !ADDRESS_TO_L2_READY_INS && !DATA_FROM_L2_VALID_INS) begin
                beat_cnt++;
                if (beat_cnt == 16) begin
                    chk_lat  = 1;
                    beat_cnt = 0;
                end
            end
            MEM_ADDRESS_READY = alt_mode ? ~MEM_ADDRESS_READY : 1'b1;
            p0_v = MEM_ADDRESS_VALID && MEM_ADDRESS_READY;
            p0_a = MEM_ADDRESS;
            if (p0_v) begin
                if (exp_addr_q.size() == 0) fail_now("mem_addr_unexpected");
                else chk("mem_addr", MEM_ADDRESS, exp_addr_q.pop_front());
            end
            stall_prev = MEM_ADDRESS_VALID && !MEM_ADDRESS_READY;
            stall_addr = MEM_ADDRESS;
        end
    end

    // Block monitor: compares each returned block and checks hold while stalled.
    initial begin : blk_monitor
        bit           hold_prev = 0;
        logic [511:0] held = '0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                hold_prev = 0;
            end else begin
                if (hold_prev) begin
                    chk("resp_valid_hold", DATA_FROM_L2_VALID_INS, 1);
                    chk("resp_data_hold", DATA_FROM_L2_INS, held);
                end
                hold_prev = DATA_FROM_L2_VALID_INS && !DATA_FROM_L2_READY_INS;
                held      = DATA_FROM_L2_INS;
                if (DATA_FROM_L2_VALID_INS && DATA_FROM_L2_READY_INS) begin
                    if (exp_blk_q.size() == 0) fail_now("block_unexpected");
                    else chk("block", DATA_FROM_L2_INS, exp_blk_q.pop_front());
                    last_blk = DATA_FROM_L2_INS;
                    hs_cyc   = cyc;
                end
            end
        end
    end

    task automatic send(input logic [29:0] addr, input bit keep, output int acc_cyc);
        bit ok = 0;
        bit r;
        push_expect(addr);
        ADDRESS_TO_L2_INS       = addr;
        ADDRESS_TO_L2_VALID_INS = 1'b1;
        acc_cyc = -1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge CLK);
            r = ADDRESS_TO_L2_READY_INS;
            if (r) acc_cyc = cyc;
            @(posedge CLK);
            ok = r;
        end
        if (!ok) fail_now("req_accept_timeout");
        #1;
        if (!keep) ADDRESS_TO_L2_VALID_INS = 1'b0;
        @(negedge CLK);
        chk("first_mem_valid", MEM_ADDRESS_VALID, 1);
        chk("busy_not_ready", ADDRESS_TO_L2_READY_INS, 0);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(posedge CLK);
            #1;
            ok = (exp_blk_q.size() == 0) && !DATA_FROM_L2_VALID_INS;
        end
        if (!ok) fail_now("block_timeout");
    endtask

    initial begin : stim
        int acc;
        bit ok;
        RST_N = 1'b0;
        ADDRESS_TO_L2_VALID_INS = 1'b0;
        ADDRESS_TO_L2_INS = '0;
        DATA_FROM_L2_READY_INS = 1'b1;
        #12;
        chk("rst_addr_ready", ADDRESS_TO_L2_READY_INS, 1);
        chk("rst_data_valid", DATA_FROM_L2_VALID_INS, 0);
        chk("rst_data", DATA_FROM_L2_INS, 0);
        chk("rst_mem_valid", MEM_ADDRESS_VALID, 0);
        chk("rst_mem_addr", MEM_ADDRESS, 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Basic fetch of block 0x40.
        send(30'h40, 0, acc);
        wait_done();
        chk("blk_msb_word", last_blk[511:480], 32'h40);
        chk("blk_lsb_word", last_blk[31:0], 32'h4F);
        first_blk = last_blk;

        // L1 stalls the response for several cycles.
        DATA_FROM_L2_READY_INS = 1'b0;
        send(30'h140, 0, acc);
        ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(posedge CLK); #1;
            ok = DATA_FROM_L2_VALID_INS;
        end
        if (!ok) fail_now("resp_valid_timeout");
        for (int n = 0; n < 5; n++) begin
            @(posedge CLK); #1;
            chk("resp_stall_addr_ready", ADDRESS_TO_L2_READY_INS, 0);
        end
        DATA_FROM_L2_READY_INS = 1'b1;
        @(posedge CLK); #1;
        chk("idle_after_hs", ADDRESS_TO_L2_READY_INS, 1);
        chk("valid_drop_after_hs", DATA_FROM_L2_VALID_INS, 0);

        // Memory ready alternating.
        alt_mode = 1;
        send(30'h2C0, 0, acc);
        wait_done();
        alt_mode = 0;
        repeat (2) @(posedge CLK);
        #1;

        // Mid-block request: ordering depends on the build, block does not.
        send(30'h45, 0, acc);
        wait_done();
        chk("blk_same_as_0x40", last_blk, first_blk);

        // Reset after 7 beats, then a clean fetch of 0x80.
        send(30'h300, 0, acc);
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(posedge CLK); #1;
            ok = (beat_cnt >= 7);
        end
        if (!ok) fail_now("beat7_timeout");
        RST_N = 1'b0;
        #1;
        chk("midrst_addr_ready", ADDRESS_TO_L2_READY_INS, 1);
        chk("midrst_data_valid", DATA_FROM_L2_VALID_INS, 0);
        chk("midrst_data", DATA_FROM_L2_INS, 0);
        chk("midrst_mem_valid", MEM_ADDRESS_VALID, 0);
        chk("midrst_mem_addr", MEM_ADDRESS, 0);
        exp_addr_q.delete();
        exp_blk_q.delete();
        @(posedge CLK); #1;
        RST_N = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        send(30'h80, 0, acc);
        wait_done();
        chk("blk_0x80_msb", last_blk[511:480], 32'h80);

        // Back-to-back requests with VALID held high.
        send(30'h100, 1, acc);
        send(30'h200, 0, acc);
        chk("second_req_accept_cycle", 32'(acc), 32'(hs_cyc + 1));
        wait_done();

        chk("addr_queue_empty", 32'(exp_addr_q.size()), 0);
        chk("blk_queue_empty", 32'(exp_blk_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
